// File: rtl/udp_reg_pkg.sv
// Shared types and constants for the UDP register ring masters.
package udp_reg_pkg;

    localparam int UDP_REG_ADDR_WIDTH  = 23;
    localparam int CPCI_NF2_DATA_WIDTH = 32;

    localparam logic [CPCI_NF2_DATA_WIDTH-1:0] DEAD_BEEF = 32'hdead_beef;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DONE      = 2'd2
    } state_t;

    // Low bit of port idx inside a packed per-port vector.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/udp_reg_master_mp_if.sv
// Core requester ports and ring in/out bundle of the multi-port register master.
interface udp_reg_master_mp_if
    import udp_reg_pkg::*;
#(
    parameter int NUM_PORTS         = 2,
    parameter int UDP_REG_SRC_WIDTH = 2
);

    logic [NUM_PORTS-1:0]                     core_reg_req;
    logic [NUM_PORTS-1:0]                     core_reg_rd_wr_L;
    logic [NUM_PORTS*UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr;
    logic [NUM_PORTS*CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data;
    logic [NUM_PORTS-1:0]                     core_reg_ack;
    logic [CPCI_NF2_DATA_WIDTH-1:0]           core_reg_rd_data;

    logic                           reg_req_out;
    logic                           reg_ack_out;
    logic                           reg_rd_wr_L_out;
    logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out;
    logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out;
    logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out;

    logic                           reg_req_in;
    logic                           reg_ack_in;
    logic                           reg_rd_wr_L_in;
    logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in;
    logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in;
    logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in;

    modport master (
        input  core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data,
        output core_reg_ack, core_reg_rd_data,
        output reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out,
        input  reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in
    );

    modport slave (
        output core_reg_req, core_reg_rd_wr_L, core_reg_addr, core_reg_wr_data,
        input  core_reg_ack, core_reg_rd_data,
        input  reg_req_out, reg_ack_out, reg_rd_wr_L_out, reg_addr_out, reg_data_out, reg_src_out,
        output reg_req_in, reg_ack_in, reg_rd_wr_L_in, reg_addr_in, reg_data_in, reg_src_in
    );

endinterface

// File: rtl/udp_reg_rr_arb.sv
// Combinational round-robin priority encoder; search begins one past last_grant.
module udp_reg_rr_arb
    import udp_reg_pkg::*;
#(
    parameter int  NUM_PORTS = 2,
    localparam int GW        = idx_width(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GW-1:0]        last_grant,
    output logic [GW-1:0]        grant,
    output logic                 any
);

    logic [GW-1:0] cand;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        cand  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = GW'((int'(last_grant) + i) % NUM_PORTS);
            if (!any && req[cand]) begin
                any   = 1'b1;
                grant = cand;
            end
        end
    end

endmodule

// File: rtl/udp_reg_master_mp.sv
// Multi-port UDP register ring master: round-robin core arbitration, tag-matched
// responses, timeout, foreign-traffic forwarding and saturating statistics.
module udp_reg_master_mp
    import udp_reg_pkg::*;
#(
    parameter int NUM_PORTS         = 2,
    parameter int SRC_ADDR          = 0,
    parameter int UDP_REG_SRC_WIDTH = 2,
    parameter int TIMEOUT_WIDTH     = 8,
    parameter int TIMEOUT           = 127,
    parameter logic [CPCI_NF2_DATA_WIDTH-1:0] TIMEOUT_RESULT = 32'hdead_0000,
    parameter int STAT_WIDTH        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    udp_reg_master_mp_if.master   bus,
    output logic [STAT_WIDTH-1:0] timeout_cnt,
    output logic [STAT_WIDTH-1:0] stray_cnt
);

    localparam int GW = idx_width(NUM_PORTS);
    localparam int AW = UDP_REG_ADDR_WIDTH;
    localparam int DW = CPCI_NF2_DATA_WIDTH;
    localparam int SW = UDP_REG_SRC_WIDTH;
    localparam logic [SW-1:0]            SRC     = SW'(SRC_ADDR);
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LOAD = TIMEOUT_WIDTH'(TIMEOUT);

    state_t                   state, state_nxt;
    logic [GW-1:0]            grant, grant_nxt, last_grant, last_grant_nxt, arb_grant;
    logic [TIMEOUT_WIDTH-1:0] count, count_nxt;
    logic                     arb_any, grant_fire, ack_fire, timeout_hit;
    logic [DW-1:0]            rd_data_nxt;
    logic                     own_rsp, foreign;

    assign own_rsp = bus.reg_req_in && (bus.reg_src_in == SRC);
    assign foreign = bus.reg_req_in && (bus.reg_src_in != SRC);

    udp_reg_rr_arb #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req        (bus.core_reg_req),
        .last_grant (last_grant),
        .grant      (arb_grant),
        .any        (arb_any)
    );

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        count_nxt      = count;
        grant_fire     = 1'b0;
        ack_fire       = 1'b0;
        timeout_hit    = 1'b0;
        rd_data_nxt    = '0;
        case (state)
            IDLE: begin
                if (arb_any && !bus.reg_req_in) begin
                    grant_fire = 1'b1;
                    grant_nxt  = arb_grant;
                    count_nxt  = TO_LOAD;
                    state_nxt  = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (count != '0) count_nxt = count - 1'b1;
                if (!bus.core_reg_req[grant]) begin
                    state_nxt = IDLE;
                end else if (own_rsp || count == '0) begin
                    ack_fire    = 1'b1;
                    timeout_hit = !own_rsp;
                    state_nxt   = DONE;
                    if (own_rsp && bus.reg_ack_in) rd_data_nxt = bus.reg_data_in;
                    else if (count == '0)          rd_data_nxt = TIMEOUT_RESULT;
                    else                           rd_data_nxt = DEAD_BEEF;
                end
            end
            DONE: begin
                if (!bus.core_reg_req[grant]) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= '0;
            count      <= '0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            count      <= count_nxt;
        end
    end

    // Foreign ring traffic wins over a fresh grant; own-tag returns are never forwarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.core_reg_ack     <= '0;
            bus.core_reg_rd_data <= '0;
            bus.reg_req_out      <= 1'b0;
            bus.reg_ack_out      <= 1'b0;
            bus.reg_rd_wr_L_out  <= 1'b0;
            bus.reg_addr_out     <= '0;
            bus.reg_data_out     <= '0;
            bus.reg_src_out      <= '0;
            timeout_cnt          <= '0;
            stray_cnt            <= '0;
        end else begin
            bus.core_reg_ack     <= ack_fire ? (NUM_PORTS'(1) << grant) : '0;
            bus.core_reg_rd_data <= rd_data_nxt;
            if (foreign) begin
                bus.reg_req_out     <= 1'b1;
                bus.reg_ack_out     <= bus.reg_ack_in;
                bus.reg_rd_wr_L_out <= bus.reg_rd_wr_L_in;
                bus.reg_addr_out    <= bus.reg_addr_in;
                bus.reg_data_out    <= bus.reg_data_in;
                bus.reg_src_out     <= bus.reg_src_in;
            end else if (grant_fire) begin
                bus.reg_req_out     <= 1'b1;
                bus.reg_ack_out     <= 1'b0;
                bus.reg_rd_wr_L_out <= bus.core_reg_rd_wr_L[arb_grant];
                bus.reg_addr_out    <= bus.core_reg_addr[slice_lo(int'(arb_grant), AW) +: AW];
                bus.reg_data_out    <= bus.core_reg_wr_data[slice_lo(int'(arb_grant), DW) +: DW];
                bus.reg_src_out     <= SRC;
            end else begin
                bus.reg_req_out     <= 1'b0;
                bus.reg_ack_out     <= 1'b0;
                bus.reg_rd_wr_L_out <= 1'b0;
                bus.reg_addr_out    <= '0;
                bus.reg_data_out    <= '0;
                bus.reg_src_out     <= '0;
            end
            if (timeout_hit && timeout_cnt != '1)
                timeout_cnt <= timeout_cnt + 1'b1;
            if (own_rsp && state != WAIT_RESP && stray_cnt != '1)
                stray_cnt <= stray_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_udp_reg_master_mp.sv
// Scoreboard bench for udp_reg_master_mp: stimulus queues expected acks and ring
// issues with their cycle, a negedge monitor pops and compares them.
module tb_udp_reg_master_mp;
    import udp_reg_pkg::*;

    localparam int NP  = 2;
    localparam int SW  = 2;
    localparam int TO  = 4;
    localparam int STW = 2;
    localparam int AW  = UDP_REG_ADDR_WIDTH;
    localparam int DW  = CPCI_NF2_DATA_WIDTH;

    logic           clk   = 1'b0;
    logic           reset = 1'b1;
    logic [STW-1:0] timeout_cnt, stray_cnt;

    udp_reg_master_mp_if #(.NUM_PORTS(NP), .UDP_REG_SRC_WIDTH(SW)) bus ();

    udp_reg_master_mp #(
        .NUM_PORTS(NP), .SRC_ADDR(0), .UDP_REG_SRC_WIDTH(SW), .TIMEOUT_WIDTH(8),
        .TIMEOUT(TO), .TIMEOUT_RESULT(32'hdead_0000), .STAT_WIDTH(STW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .timeout_cnt (timeout_cnt),
        .stray_cnt   (stray_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [NP-1:0] mask;
        logic [DW-1:0] data;
    } ack_exp_t;

    typedef struct {
        int          cyc;
        logic [63:0] payload;
    } ring_exp_t;

    ack_exp_t  ack_q[$];
    ring_exp_t ring_q[$];
    ack_exp_t  ae;
    ring_exp_t re;
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] ring_pack(input logic rw, input logic ack,
                                              input logic [AW-1:0] a, input logic [DW-1:0] d,
                                              input logic [SW-1:0] s);
        return {5'b0, rw, ack, a, d, s};
    endfunction

    always @(negedge clk) begin
        if (|bus.core_reg_ack) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", {bus.core_reg_ack, bus.core_reg_rd_data}, 64'h0);
            end else begin
                ae = ack_q.pop_front();
                chk("ack_cycle", 64'(cyc), 64'(ae.cyc));
                chk("ack_port_data", {bus.core_reg_ack, bus.core_reg_rd_data}, {ae.mask, ae.data});
            end
        end
        if (bus.reg_req_out === 1'b1) begin
            if (ring_q.size() == 0) begin
                chk("unexpected_ring_req", 64'(bus.reg_addr_out), 64'h0);
            end else begin
                re = ring_q.pop_front();
                chk("ring_cycle", 64'(cyc), 64'(re.cyc));
                chk("ring_fields", ring_pack(bus.reg_rd_wr_L_out, bus.reg_ack_out, bus.reg_addr_out,
                                             bus.reg_data_out, bus.reg_src_out), re.payload);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.core_reg_rd_wr_L[p]        = rw;
        bus.core_reg_addr[p*AW +: AW]  = a;
        bus.core_reg_wr_data[p*DW +: DW] = d;
        bus.core_reg_req[p]            = 1'b1;
    endtask

    task automatic ring_in(input logic rq, input logic ak, input logic rw, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        bus.reg_req_in     = rq;
        bus.reg_ack_in     = ak;
        bus.reg_rd_wr_L_in = rw;
        bus.reg_addr_in    = a;
        bus.reg_data_in    = d;
        bus.reg_src_in     = s;
    endtask

    task automatic push_ring(input int c, input logic [63:0] pl);
        ring_exp_t e;
        e.cyc = c;
        e.payload = pl;
        ring_q.push_back(e);
    endtask

    task automatic push_ack(input int c, input int p, input logic [DW-1:0] d);
        ack_exp_t e;
        e.cyc  = c;
        e.mask = NP'(1) << p;
        e.data = d;
        ack_q.push_back(e);
    endtask

    task automatic push_issue(input int c, input int p);
        push_ring(c, ring_pack(bus.core_reg_rd_wr_L[p], 1'b0, bus.core_reg_addr[p*AW +: AW],
                               bus.core_reg_wr_data[p*DW +: DW], '0));
    endtask

    // Called in the idle cycle where port p is expected to win; dly < 0 means no response.
    task automatic do_access(input int p, input int dly, input logic rsp_ack, input logic [DW-1:0] rsp_data);
        int s;
        s = cyc;
        push_issue(s + 1, p);
        if (dly < 0) begin
            push_ack(s + TO + 2, p, 32'hdead_0000);
            tick(TO + 2);
        end else begin
            push_ack(s + 2 + dly, p, rsp_ack ? rsp_data : 32'hdead_beef);
            tick(1 + dly);
            ring_in(1'b1, rsp_ack, bus.core_reg_rd_wr_L[p], bus.core_reg_addr[p*AW +: AW], rsp_data, '0);
            tick(1);
            ring_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        end
        bus.core_reg_req[p] = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_core_ack"}, 64'(bus.core_reg_ack), 64'h0);
        chk({tag, "_rd_data"}, 64'(bus.core_reg_rd_data), 64'h0);
        chk({tag, "_ring_ctl"}, {bus.reg_req_out, bus.reg_ack_out, bus.reg_rd_wr_L_out,
                                 bus.reg_src_out, bus.reg_addr_out}, 64'h0);
        chk({tag, "_ring_data"}, 64'(bus.reg_data_out), 64'h0);
        chk({tag, "_stats"}, {timeout_cnt, stray_cnt}, 64'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.core_reg_req     = '0;
        bus.core_reg_rd_wr_L = '0;
        bus.core_reg_addr    = '0;
        bus.core_reg_wr_data = '0;
        ring_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        reset = 1'b1;
        tick(3);
        check_zero("reset");
        reset = 1'b0;
        tick(2);

        // single read, response at count==1
        set_port(0, 1'b1, 23'h10, 32'h0);
        do_access(0, 3, 1'b1, 32'h1234_5678);
        tick(1);

        // round robin with both ports competing
        set_port(0, 1'b0, 23'h20, 32'haaaa_0000);
        set_port(1, 1'b1, 23'h30, 32'h0);
        do_access(1, 0, 1'b1, 32'h1111_0001);
        tick(1);
        bus.core_reg_req[1] = 1'b1;
        do_access(0, 0, 1'b1, 32'haaaa_0000);
        tick(1);
        bus.core_reg_req[0] = 1'b1;
        do_access(1, 1, 1'b1, 32'h1111_0002);
        tick(1);
        bus.core_reg_req[1] = 1'b1;
        do_access(0, 0, 1'b1, 32'haaaa_0000);
        bus.core_reg_req[1] = 1'b0;
        tick(1);

        // timeout
        set_port(0, 1'b1, 23'h40, 32'h0);
        do_access(0, -1, 1'b0, 32'h0);
        chk("timeout_cnt_after_timeout", 64'(timeout_cnt), 64'd1);
        tick(1);

        // loop complete without ack
        set_port(1, 1'b1, 23'h50, 32'h0);
        do_access(1, 2, 1'b0, 32'h9999_9999);
        chk("timeout_cnt_after_noack", 64'(timeout_cnt), 64'd1);
        tick(1);

        // response on the deadline cycle wins over the timeout
        set_port(0, 1'b1, 23'h58, 32'h0);
        do_access(0, TO, 1'b1, 32'hcafe_f00d);
        chk("timeout_cnt_after_deadline_rsp", 64'(timeout_cnt), 64'd1);
        tick(1);

        // foreign traffic is forwarded and defers port 1
        s = cyc;
        ring_in(1'b1, 1'b1, 1'b1, 23'h7_1234, 32'h5555_aaaa, 2'd2);
        set_port(1, 1'b0, 23'h60, 32'h0bad_cafe);
        push_ring(s + 1, ring_pack(1'b1, 1'b1, 23'h7_1234, 32'h5555_aaaa, 2'd2));
        push_ring(s + 2, ring_pack(1'b1, 1'b1, 23'h7_1234, 32'h5555_aaaa, 2'd2));
        tick(2);
        ring_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        do_access(1, 0, 1'b1, 32'h0bad_cafe);
        tick(1);

        // abandon, stray response, then reset mid-access
        s = cyc;
        set_port(0, 1'b1, 23'h70, 32'h0);
        push_issue(s + 1, 0);
        tick(2);
        bus.core_reg_req[0] = 1'b0;
        tick(2);
        ring_in(1'b1, 1'b1, 1'b1, 23'h70, 32'h7777_7777, '0);
        tick(1);
        ring_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("stray_cnt_after_abandon", 64'(stray_cnt), 64'd1);
        set_port(1, 1'b1, 23'h80, 32'h0);
        push_issue(s + 6, 1);
        tick(2);
        reset = 1'b1;
        bus.core_reg_req[1] = 1'b0;
        tick(1);
        check_zero("mid_reset");
        reset = 1'b0;
        tick(1);
        ring_in(1'b1, 1'b1, 1'b1, 23'h80, 32'h8888_8888, '0);
        tick(1);
        chk("stray_cnt_after_reset", 64'(stray_cnt), 64'd1);
        tick(3);
        ring_in(1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("stray_cnt_saturated", 64'(stray_cnt), 64'd3);

        tick(3);
        chk("ack_queue_drained", 64'(ack_q.size()), 64'd0);
        chk("ring_queue_drained", 64'(ring_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
